// File: rtl/ps2_pkg.sv
// Shared constants and types for the PS/2 Set-2 scancode sequencer.
package ps2_pkg;

  localparam logic [7:0] PS2_EXT  = 8'hE0;
  localparam logic [7:0] PS2_BRK  = 8'hF0;
  localparam logic [7:0] PS2_ERR0 = 8'h00;
  localparam logic [7:0] PS2_ERR1 = 8'hFF;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXT,
    ST_BRK,
    ST_EXT_BRK
  } prefix_state_t;

  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] code;
  } ps2_event_t;

endpackage

// File: rtl/ps2_event_fifo.sv
// First-word-fall-through event FIFO; a pop frees a slot for a same-cycle push when full.
module ps2_event_fifo
  import ps2_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       push,
  input  logic       pop,
  input  ps2_event_t din,
  output ps2_event_t dout,
  output logic       empty,
  output logic       full,
  output logic [AW:0] count
);

  ps2_event_t mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

endmodule

// File: rtl/ps2_scancode_ctrl.sv
// Tracks E0/F0 prefixes from the PS/2 decoder and queues complete key events for the host.
module ps2_scancode_ctrl
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 1_000_000,
  localparam int CW = $clog2(FIFO_DEPTH) + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [7:0]    rx_data,
  input  logic          rx_valid,
  input  logic          rd_req,
  input  logic          clr_flags,
  output logic [7:0]    ev_code,
  output logic          ev_break,
  output logic          ev_ext,
  output logic          ev_valid,
  output logic [CW-1:0] ev_count,
  output logic          overflow,
  output logic          line_err
);

  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  prefix_state_t state;
  prefix_state_t next_state;
  logic [TW-1:0] timer;
  logic          emit;
  logic          set_err;
  logic          timeout;
  logic          in_ext;
  logic          in_brk;
  ps2_event_t    new_ev;
  ps2_event_t    head;
  logic          fifo_full;
  logic          fifo_empty;

  assign in_ext = (state == ST_EXT) || (state == ST_EXT_BRK);
  assign in_brk = (state == ST_BRK) || (state == ST_EXT_BRK);

  // A prefix arriving after F0 is a protocol error, but it still starts a fresh sequence.
  always_comb begin
    next_state = state;
    emit       = 1'b0;
    set_err    = 1'b0;
    timeout    = 1'b0;
    new_ev     = '0;
    if (rx_valid) begin
      if (rx_data == PS2_ERR0 || rx_data == PS2_ERR1) begin
        set_err    = 1'b1;
        next_state = ST_IDLE;
      end else if (rx_data == PS2_EXT) begin
        set_err    = in_brk;
        next_state = ST_EXT;
      end else if (rx_data == PS2_BRK) begin
        set_err    = in_brk;
        next_state = (state == ST_EXT) ? ST_EXT_BRK : ST_BRK;
      end else begin
        emit       = 1'b1;
        new_ev     = '{ext: in_ext, brk: in_brk, code: rx_data};
        next_state = ST_IDLE;
      end
    end else if (state != ST_IDLE && timer == TMO_LAST) begin
      timeout    = 1'b1;
      set_err    = 1'b1;
      next_state = ST_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      timer    <= '0;
      overflow <= 1'b0;
      line_err <= 1'b0;
    end else begin
      state <= next_state;
      timer <= (rx_valid || state == ST_IDLE || timeout) ? '0 : timer + 1'b1;
      if (emit && fifo_full && !rd_req) overflow <= 1'b1;
      else if (clr_flags)               overflow <= 1'b0;
      if (set_err)        line_err <= 1'b1;
      else if (clr_flags) line_err <= 1'b0;
    end
  end

  ps2_event_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (emit),
    .pop   (rd_req),
    .din   (new_ev),
    .dout  (head),
    .empty (fifo_empty),
    .full  (fifo_full),
    .count (ev_count)
  );

  assign ev_code  = head.code;
  assign ev_break = head.brk;
  assign ev_ext   = head.ext;
  assign ev_valid = !fifo_empty;

endmodule

// File: tb/tb_ps2_scancode_ctrl.sv
// Directed plus randomized checks of the scancode sequencer against a byte-history reference model.
module tb_ps2_scancode_ctrl;

  localparam int DEPTH = 4;
  localparam int TMO   = 64;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [7:0]    rx_data = 8'h00;
  logic          rx_valid = 1'b0;
  logic          rd_req = 1'b0;
  logic          clr_flags = 1'b0;
  logic [7:0]    ev_code;
  logic          ev_break;
  logic          ev_ext;
  logic          ev_valid;
  logic [CW-1:0] ev_count;
  logic          overflow;
  logic          line_err;

  int tests = 0;
  int fails = 0;

  // Reference model: queued events as {ext, brk, code}, plus the prefix bytes seen since the last event.
  logic [9:0] mq[$];
  logic [7:0] pend[$];
  int         idle = 0;
  bit         m_ovf = 1'b0;
  bit         m_err = 1'b0;

  ps2_scancode_ctrl #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)) dut (
    .clk       (clk),
    .reset     (reset),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rd_req    (rd_req),
    .clr_flags (clr_flags),
    .ev_code   (ev_code),
    .ev_break  (ev_break),
    .ev_ext    (ev_ext),
    .ev_valid  (ev_valid),
    .ev_count  (ev_count),
    .overflow  (overflow),
    .line_err  (line_err)
  );

  always #5 clk = ~clk;

  function automatic bit pendHas(input logic [7:0] b);
    for (int i = 0; i < pend.size(); i++)
      if (pend[i] == b) return 1'b1;
    return 1'b0;
  endfunction

  task automatic modelCycle(input bit rxv, input logic [7:0] d, input bit rd,
                            input bit clr, input bit rst);
    bit         set_e;
    bit         set_o;
    bit         emit;
    logic [9:0] ev;
    if (rst) begin
      mq.delete();
      pend.delete();
      idle  = 0;
      m_ovf = 1'b0;
      m_err = 1'b0;
      return;
    end
    set_e = 1'b0;
    set_o = 1'b0;
    emit  = 1'b0;
    ev    = '0;
    if (rxv) begin
      idle = 0;
      if (d == 8'h00 || d == 8'hFF) begin
        set_e = 1'b1;
        pend.delete();
      end else if (d == 8'hE0 || d == 8'hF0) begin
        if (pendHas(8'hF0)) begin
          set_e = 1'b1;
          pend.delete();
        end
        pend.push_back(d);
      end else begin
        emit = 1'b1;
        ev   = {pendHas(8'hE0), pendHas(8'hF0), d};
        pend.delete();
      end
    end else if (pend.size() > 0) begin
      idle++;
      if (idle == TMO) begin
        set_e = 1'b1;
        pend.delete();
        idle = 0;
      end
    end
    if (rd && mq.size() > 0) void'(mq.pop_front());
    if (emit) begin
      if (mq.size() < DEPTH) mq.push_back(ev);
      else set_o = 1'b1;
    end
    if (set_o) m_ovf = 1'b1; else if (clr) m_ovf = 1'b0;
    if (set_e) m_err = 1'b1; else if (clr) m_err = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input bit rxv, input logic [7:0] d, input bit rd,
                               input bit clr, input bit rst);
    rx_valid  = rxv;
    rx_data   = d;
    rd_req    = rd;
    clr_flags = clr;
    reset     = rst;
    modelCycle(rxv, d, rd, clr, rst);
    @(posedge clk);
    #1;
    rx_valid  = 1'b0;
    rd_req    = 1'b0;
    clr_flags = 1'b0;
    reset     = 1'b0;
  endtask

  task automatic checkOutput(input string tag);
    chk({tag, ".valid"}, 32'(ev_valid), 32'(mq.size() > 0));
    chk({tag, ".count"}, 32'(ev_count), 32'(mq.size()));
    chk({tag, ".ovf"},   32'(overflow), 32'(m_ovf));
    chk({tag, ".err"},   32'(line_err), 32'(m_err));
    if (mq.size() > 0)
      chk({tag, ".head"}, 32'({ev_ext, ev_break, ev_code}), 32'(mq[0]));
  endtask

  task automatic sendByte(input logic [7:0] d, input string tag);
    applyStimulus(1'b1, d, 1'b0, 1'b0, 1'b0);
    checkOutput(tag);
  endtask

  task automatic popOne(input string tag);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    checkOutput(tag);
  endtask

  task automatic idleCycles(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
      checkOutput(tag);
    end
  endtask

  initial begin
    logic [7:0] d;
    bit         rxv;
    bit         rd;
    bit         clr;
    int         r;

    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    checkOutput("reset");
    chk("reset.outs", 32'({ev_ext, ev_break, ev_code, ev_valid, overflow, line_err}), 32'h0);

    sendByte(8'h1C, "make");
    chk("make.ev", 32'({ev_ext, ev_break, ev_code}), 32'h01C);
    sendByte(8'hE0, "e0");
    sendByte(8'h74, "ext_make");
    chk("ext_make.cnt", 32'(ev_count), 32'd2);
    popOne("pop1");
    chk("pop1.ev", 32'({ev_ext, ev_break, ev_code}), 32'h274);
    popOne("pop2");

    sendByte(8'hF0, "f0");
    chk("f0.noev", 32'(ev_valid), 32'd0);
    sendByte(8'h1C, "brk");
    chk("brk.ev", 32'({ev_ext, ev_break, ev_code}), 32'h11C);
    sendByte(8'hE0, "e0b");
    sendByte(8'hF0, "e0f0");
    sendByte(8'h74, "ext_brk");
    popOne("pop3");
    chk("pop3.ev", 32'({ev_ext, ev_break, ev_code}), 32'h374);
    popOne("pop4");

    sendByte(8'hE0, "tmo_edge_e0");
    idleCycles(TMO - 1, "tmo_edge_wait");
    sendByte(8'h74, "tmo_edge_byte");
    chk("tmo_edge.err", 32'(line_err), 32'd0);
    chk("tmo_edge.ev", 32'({ev_ext, ev_break, ev_code}), 32'h274);
    popOne("pop5");
    sendByte(8'hE0, "tmo_e0");
    idleCycles(TMO, "tmo_wait");
    chk("tmo.err", 32'(line_err), 32'd1);
    sendByte(8'h1C, "tmo_byte");
    chk("tmo.ev", 32'({ev_ext, ev_break, ev_code}), 32'h01C);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
    checkOutput("clr");
    chk("clr.err", 32'(line_err), 32'd0);

    for (int i = 0; i < 5; i++) sendByte(8'h15 + 8'(i), "fill");
    chk("full.cnt", 32'(ev_count), 32'd4);
    chk("full.ovf", 32'(overflow), 32'd1);
    chk("full.head", 32'(ev_code), 32'h15);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    checkOutput("clr_ovf");
    applyStimulus(1'b1, 8'h1A, 1'b1, 1'b0, 1'b0);
    checkOutput("push_pop_full");
    chk("ppf.cnt", 32'(ev_count), 32'd4);
    chk("ppf.ovf", 32'(overflow), 32'd0);
    for (int i = 0; i < 4; i++) popOne("drain");

    sendByte(8'hF0, "perr_f0");
    sendByte(8'hE0, "perr_e0");
    sendByte(8'h70, "perr_code");
    chk("perr.ev", 32'({ev_ext, ev_break, ev_code}), 32'h270);
    chk("perr.err", 32'(line_err), 32'd1);
    popOne("pop6");
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    checkOutput("clr2");
    sendByte(8'h00, "errbyte");
    chk("errbyte.err", 32'(line_err), 32'd1);
    chk("errbyte.noev", 32'(ev_valid), 32'd0);

    sendByte(8'hE0, "rst_e0");
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    checkOutput("rst_mid");
    sendByte(8'h1C, "rst_byte");
    chk("rst.ev", 32'({ev_ext, ev_break, ev_code}), 32'h01C);
    popOne("pop7");
    popOne("pop_empty");
    chk("empty.cnt", 32'(ev_count), 32'd0);

    for (int n = 0; n < 500; n++) begin
      if ($urandom_range(0, 39) == 0) idleCycles($urandom_range(TMO - 4, TMO + 4), "rnd_gap");
      r = $urandom_range(0, 11);
      case (r)
        0, 1:    d = 8'hE0;
        2, 3:    d = 8'hF0;
        4:       d = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'hFF;
        default: d = 8'($urandom);
      endcase
      rxv = ($urandom_range(0, 2) != 0);
      rd  = ($urandom_range(0, 3) == 0);
      clr = ($urandom_range(0, 15) == 0);
      applyStimulus(rxv, d, rd, clr, 1'b0);
      checkOutput("rnd");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ps2_scancode_ctrl.md
# ps2_scancode_ctrl

Sequencer and buffer between `ps2_decoder` and the 68k-side register interface. It consumes raw bytes from the decoder's `data`/`valid` outputs and tracks PS/2 Set-2 prefix bytes (E0 extended, F0 break). It emits complete key events of the form {extended, break, code} into a small first-word-fall-through FIFO. The host pops events at its own pace; overflow and line errors are reported as sticky flags.

## Interface
Parameters:
- `FIFO_DEPTH`, default 4: event entries; must be a power of 2, minimum 2.
- `TIMEOUT_CYCLES`, default 1_000_000: clocks a prefix state may wait for the next byte before it is abandoned; minimum 2.

Ports:
- `clk` in 1: the single clock; all logic is on its rising edge.
- `reset` in 1: synchronous, active-high.
- `rx_data` in 8: byte from `ps2_decoder.data`.
- `rx_valid` in 1: one-cycle strobe per received byte (`ps2_decoder.valid`).
- `rd_req` in 1: host pops the head event; ignored when empty.
- `clr_flags` in 1: clears `overflow` and `line_err`.
- `ev_code` out 8: scancode of the head event.
- `ev_break` out 1: head event is a key release.
- `ev_ext` out 1: head event carried the E0 prefix.
- `ev_valid` out 1: FIFO is not empty.
- `ev_count` out clog2(FIFO_DEPTH)+1: number of occupied entries.
- `overflow` out 1: sticky; an event was dropped because the FIFO was full.
- `line_err` out 1: sticky; an error byte or a prefix timeout occurred.

## Operation
- Prefix FSM states: IDLE, EXT (E0 seen), BRK (F0 seen), EXT_BRK (E0 F0 seen). State changes only on cycles where `rx_valid`=1, except for timeout.
- IDLE: E0 goes to EXT; F0 goes to BRK; 00 or FF sets `line_err` and stays in IDLE; any other byte emits {ext=0, brk=0, code} and stays in IDLE.
- EXT: F0 goes to EXT_BRK; E0 stays in EXT; 00/FF sets `line_err` and goes to IDLE; any other byte emits {1, 0, code} and goes to IDLE.
- BRK: other byte emits {0, 1, code} and goes to IDLE; E0 or F0 is a protocol error: set `line_err` and re-enter as if from IDLE (E0 goes to EXT, F0 goes to BRK); 00/FF sets `line_err` and goes to IDLE.
- EXT_BRK: other byte emits {1, 1, code} and goes to IDLE; E0/F0/00/FF are handled the same way as in BRK.
- E1 (Pause) and the controller replies (AA, FA, FE, EE) are not special: they are emitted as ordinary codes.
- Timeout counter:
  - Counts only in non-IDLE states.
  - Clears on every `rx_valid`.
  - On reaching TIMEOUT_CYCLES-1 it forces IDLE and sets `line_err`.
  - A byte arriving in the same cycle as the timeout takes priority over the timeout.
- FIFO push (emit):
  - Not full: the event is written.
  - Full with `rd_req`=1 in the same cycle: pop and push both happen; count is unchanged; no overflow.
  - Full with `rd_req`=0: the new event is dropped and `overflow` is set.
- Pop: `rd_req`=1 with `ev_valid`=1 advances the head. With the FIFO empty, `rd_req` is a no-op.
- Read and write pointers use clog2(FIFO_DEPTH) bits and wrap modulo FIFO_DEPTH. `ev_count` = writes minus reads and never exceeds FIFO_DEPTH.
- Flag priority: a set event in the same cycle as `clr_flags` wins, so the flag ends up 1.
- Reset values: FSM in IDLE, timeout counter 0, FIFO empty, all outputs 0.

## Timing
- A final byte strobed in cycle N produces `ev_valid`=1 in cycle N+1, with the event on `ev_*` (FWFT, 1-cycle latency).
- Prefix bytes produce no output.
- `rd_req` in cycle N exposes the next head (or `ev_valid`=0) in cycle N+1.
- `ev_*` hold steady while `ev_valid`=1 and no pop occurs. They are don't-care while `ev_valid`=0.
- `overflow` and `line_err` assert in the cycle after the causing event.
- A reset asserted mid-sequence (for example after E0) discards the pending prefix and all queued events within one cycle.

## Structure
- Package `ps2_pkg`:
  - Byte constants PS2_EXT=8'hE0, PS2_BRK=8'hF0, PS2_ERR0=8'h00, PS2_ERR1=8'hFF.
  - Prefix-state enum.
  - 10-bit event typedef {ext, brk, code[7:0]}.
- Sub-module `ps2_event_fifo`:
  - Parameterized depth, synchronous-reset FWFT FIFO.
  - Ports: push, pop, din, dout, empty, full, count.
- The FSM, timeout counter and flags stay in the top module.

## Test plan
- Bytes 1C, then E0 74, with pops → events {0,0,1C} then {1,0,74}; `ev_count` goes 1, 2, 1, 0.
- Bytes F0 1C, then E0 F0 74 → {0,1,1C}, then {1,1,74}; no event for any prefix byte.
- Byte E0 then 1,000,000 idle cycles, then 1C → `line_err`=1, event {0,0,1C} (ext cleared); `clr_flags` returns `line_err` to 0.
- Five codes 15 16 17 18 19 with no pops and FIFO_DEPTH=4 → `ev_count`=4, `overflow`=1, head events 15..18. Then a push concurrent with `rd_req` while full → count stays 4, no new overflow.
- Bytes F0 E0 70 → `line_err`=1, event {1,0,70}. Byte 00 → `line_err`=1, no event.
- E0 followed by `reset` for one cycle, then 1C → single event {0,0,1C}. `rd_req` while empty → `ev_count` stays 0.
